// File: rtl/dds_param_scheduler.sv
// Timed parameter scheduler for the DDS datapath.
// Time-tagged commands arrive over AXI-Stream, wait in an in-order FIFO and
// are applied to the DDS parameter registers when their exec_time comes up.
// The free-running coarse timestamp is generated here as well.
module dds_param_scheduler #(
  parameter int FIFO_DEPTH = 16,
  parameter int LATE_CNT_W = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [127:0]                  s_axis_tdata,
  input  logic                          s_axis_tvalid,
  output logic                          s_axis_tready,
  output logic [63:0]                   timestamp,
  output logic [47:0]                   freq,
  output logic [13:0]                   amp,
  output logic [13:0]                   phase,
  output logic [13:0]                   amp_offset,
  output logic [63:0]                   time_offset,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          late_flag,
  output logic [LATE_CNT_W-1:0]         late_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  localparam logic [1:0] OP_FREQ   = 2'd0;
  localparam logic [1:0] OP_AMPPH  = 2'd1;
  localparam logic [1:0] OP_AOFF   = 2'd2;
  localparam logic [1:0] OP_TRESET = 2'd3;

  // Command storage, split by field; reserved bits are not kept.
  logic [63:0] mem_time [FIFO_DEPTH];
  logic [1:0]  mem_op   [FIFO_DEPTH];
  logic [47:0] mem_pay  [FIFO_DEPTH];

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  logic [63:0] head_time;
  logic [1:0]  head_op;
  logic [47:0] head_pay;
  logic [64:0] ts_next;
  logic        push;
  logic        pop;
  logic        head_due;
  logic        head_late;

  logic        unused_rsvd;
  assign unused_rsvd = ^s_axis_tdata[61:48];

  assign s_axis_tready = (fifo_count != CW'(FIFO_DEPTH));
  assign push          = s_axis_tvalid && s_axis_tready;

  assign head_time = mem_time[rd_ptr];
  assign head_op   = mem_op[rd_ptr];
  assign head_pay  = mem_pay[rd_ptr];

  // Due/late decisions look one cycle ahead so the register update lands in
  // the same cycle the timestamp reads exec_time. The compare is 65 bits wide
  // so timestamp+1 never wraps into the comparison.
  assign ts_next   = {1'b0, timestamp} + 65'd1;
  assign head_due  = ({1'b0, head_time} <= ts_next);
  assign head_late = ({1'b0, head_time} <  ts_next);
  // Occupancy is the registered count, so a word pushed this edge cannot pop
  // until the next one (one-cycle minimum residency).
  assign pop       = (fifo_count != '0) && head_due;

  // FIFO storage write; contents need no reset because the pointers define validity.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_time[wr_ptr] <= s_axis_tdata[127:64];
      mem_op[wr_ptr]   <= s_axis_tdata[63:62];
      mem_pay[wr_ptr]  <= s_axis_tdata[47:0];
    end
  end

  // FIFO pointers and occupancy; reset flushes every queued command.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CW'(1);
        2'b01:   fifo_count <= fifo_count - CW'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // Free-running coarse timestamp.
  always_ff @(posedge clk) begin
    if (reset) timestamp <= '0;
    else       timestamp <= timestamp + 64'd1;
  end

  // Apply the head command to the parameter registers and track lateness.
  always_ff @(posedge clk) begin
    if (reset) begin
      freq        <= '0;
      amp         <= '0;
      phase       <= '0;
      amp_offset  <= '0;
      time_offset <= '0;
      late_flag   <= 1'b0;
      late_count  <= '0;
    end else if (pop) begin
      case (head_op)
        OP_FREQ:   freq <= head_pay;
        OP_AMPPH: begin
          amp   <= head_pay[13:0];
          phase <= head_pay[29:16];
        end
        OP_AOFF:   amp_offset  <= head_pay[13:0];
        OP_TRESET: time_offset <= head_time;
        default:   freq <= freq;
      endcase
      if (head_late) begin
        late_flag <= 1'b1;
        if (late_count != '1) late_count <= late_count + LATE_CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_dds_param_scheduler.sv
// Scoreboard bench for dds_param_scheduler: directed commands push the
// expected parameter snapshot (including the timestamp it must appear at);
// a monitor pops and compares whenever the parameter outputs change.
module tb_dds_param_scheduler;

  localparam int FIFO_DEPTH = 16;
  localparam int LATE_CNT_W = 16;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic                  clk;
  logic                  reset;
  logic [127:0]          s_axis_tdata;
  logic                  s_axis_tvalid;
  logic                  s_axis_tready;
  logic [63:0]           timestamp;
  logic [47:0]           freq;
  logic [13:0]           amp;
  logic [13:0]           phase;
  logic [13:0]           amp_offset;
  logic [63:0]           time_offset;
  logic [CW-1:0]         fifo_count;
  logic                  late_flag;
  logic [LATE_CNT_W-1:0] late_count;

  dds_param_scheduler #(.FIFO_DEPTH(FIFO_DEPTH), .LATE_CNT_W(LATE_CNT_W)) dut (
    .clk(clk), .reset(reset),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready), .timestamp(timestamp),
    .freq(freq), .amp(amp), .phase(phase), .amp_offset(amp_offset),
    .time_offset(time_offset), .fifo_count(fifo_count),
    .late_flag(late_flag), .late_count(late_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] ts;
    logic [47:0] freq;
    logic [13:0] amp;
    logic [13:0] phase;
    logic [13:0] aoff;
    logic [63:0] toff;
    logic        lflag;
    logic [15:0] lcnt;
  } snap_t;

  snap_t exp_q[$];
  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, expv, $time);
    end
  endtask

  task automatic exp_push(input logic [63:0] ts, input logic [47:0] f, input logic [13:0] a,
                          input logic [13:0] p, input logic [13:0] ao, input logic [63:0] to,
                          input logic lf, input logic [15:0] lc);
    snap_t s;
    s.ts = ts; s.freq = f; s.amp = a; s.phase = p; s.aoff = ao; s.toff = to;
    s.lflag = lf; s.lcnt = lc;
    exp_q.push_back(s);
  endtask

  // Monitor: any change of the parameter outputs is one DUT "response".
  initial begin
    logic [170:0] prev_v;
    logic [170:0] cur_v;
    snap_t e;
    prev_v = '0;
    forever begin
      @(negedge clk);
      cur_v = {freq, amp, phase, amp_offset, time_offset, late_flag, late_count};
      if (reset) begin
        prev_v = cur_v;
      end else if (cur_v !== prev_v) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_update ts=%0d freq=%0h amp=%0h phase=%0h aoff=%0h toff=%0h lf=%0b lc=%0d expected=none",
                   timestamp, freq, amp, phase, amp_offset, time_offset, late_flag, late_count);
        end else begin
          e = exp_q.pop_front();
          chk("upd_timestamp", timestamp, e.ts);
          chk("upd_freq", 64'(freq), 64'(e.freq));
          chk("upd_amp", 64'(amp), 64'(e.amp));
          chk("upd_phase", 64'(phase), 64'(e.phase));
          chk("upd_amp_offset", 64'(amp_offset), 64'(e.aoff));
          chk("upd_time_offset", time_offset, e.toff);
          chk("upd_late_flag", 64'(late_flag), 64'(e.lflag));
          chk("upd_late_count", 64'(late_count), 64'(e.lcnt));
        end
        prev_v = cur_v;
      end
    end
  end

  // Advance to the cycle in which timestamp reads t (inputs driven #1 after posedge).
  task automatic wait_ts(input logic [63:0] t);
    int unsigned n;
    n = 0;
    @(posedge clk); #1;
    while (timestamp != t && n < 30000) begin
      @(posedge clk); #1;
      n++;
    end
    chk("wait_timestamp", timestamp, t);
  endtask

  // Hold a command on the bus until accepted; acc_ts is the timestamp of the accepting cycle.
  task automatic send(input logic [63:0] et, input logic [1:0] op, input logic [47:0] pl,
                      output logic [63:0] acc_ts);
    int unsigned n;
    logic acc;
    n = 0;
    acc_ts = '0;
    s_axis_tdata  = {et, op, 14'h2AAA, pl};
    s_axis_tvalid = 1'b1;
    do begin
      acc    = s_axis_tready;
      acc_ts = timestamp;
      @(posedge clk); #1;
      n++;
    end while (!acc && n < 20000);
    s_axis_tvalid = 1'b0;
    if (!acc) begin
      checks++;
      failures++;
      $display("FAIL send_timeout actual=not_accepted expected=accepted exec_time=%0d", et);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_freq"}, 64'(freq), 64'd0);
    chk({tag, "_amp"}, 64'(amp), 64'd0);
    chk({tag, "_phase"}, 64'(phase), 64'd0);
    chk({tag, "_amp_offset"}, 64'(amp_offset), 64'd0);
    chk({tag, "_time_offset"}, time_offset, 64'd0);
    chk({tag, "_fifo_count"}, 64'(fifo_count), 64'd0);
    chk({tag, "_late_flag"}, 64'(late_flag), 64'd0);
    chk({tag, "_late_count"}, 64'(late_count), 64'd0);
  endtask

  initial begin
    logic [63:0] acc_ts;
    reset         = 1'b1;
    s_axis_tvalid = 1'b0;
    s_axis_tdata  = '0;

    // Reset for 3 cycles, then all zero, tready high, timestamp counts 0,1,2.
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk_all_zero("reset");
    chk("reset_tready", 64'(s_axis_tready), 64'd1);
    chk("reset_ts0", timestamp, 64'd0);
    @(negedge clk);
    chk("reset_ts1", timestamp, 64'd1);
    @(negedge clk);
    chk("reset_ts2", timestamp, 64'd2);

    // On-time frequency update at timestamp 100.
    wait_ts(64'd10);
    exp_push(64'd100, 48'h0000_1234_5678, 14'h0, 14'h0, 14'h0, 64'd0, 1'b0, 16'd0);
    send(64'd100, 2'd0, 48'h0000_1234_5678, acc_ts);

    // Ordered burst: amp/phase @200, amp_offset one cycle late, time restart @300.
    wait_ts(64'd150);
    exp_push(64'd200, 48'h0000_1234_5678, 14'h1FFF, 14'h0100, 14'h0, 64'd0, 1'b0, 16'd0);
    exp_push(64'd201, 48'h0000_1234_5678, 14'h1FFF, 14'h0100, 14'h0010, 64'd0, 1'b1, 16'd1);
    exp_push(64'd300, 48'h0000_1234_5678, 14'h1FFF, 14'h0100, 14'h0010, 64'd300, 1'b1, 16'd1);
    send(64'd200, 2'd1, 48'h0000_0100_1FFF, acc_ts);
    send(64'd200, 2'd2, 48'h0000_0000_0010, acc_ts);
    send(64'd300, 2'd3, 48'hFFFF_FFFF_FFFF, acc_ts);

    // Late command accepted at 500 executes at 502.
    wait_ts(64'd500);
    exp_push(64'd502, 48'h0000_00AB_CDEF, 14'h1FFF, 14'h0100, 14'h0010, 64'd300, 1'b1, 16'd2);
    send(64'd50, 2'd0, 48'h0000_00AB_CDEF, acc_ts);
    chk("late_accept_ts", acc_ts, 64'd500);

    // Full FIFO: 16 accepted, 17th waits for the first pop at 10000.
    wait_ts(64'd600);
    for (int k = 0; k < 17; k++) begin
      exp_push(64'd10000 + 64'(k), 48'(k + 1), 14'h1FFF, 14'h0100, 14'h0010, 64'd300, 1'b1,
               (k == 0) ? 16'd2 : 16'(2 + k));
    end
    for (int k = 0; k < 16; k++) send(64'd10000, 2'd0, 48'(k + 1), acc_ts);
    chk("full_fifo_count", 64'(fifo_count), 64'd16);
    chk("full_tready", 64'(s_axis_tready), 64'd0);
    send(64'd10000, 2'd0, 48'd17, acc_ts);
    chk("full_17th_accept_ts", acc_ts, 64'd10000);

    // Reset mid-run discards 8 queued commands.
    wait_ts(64'd10030);
    for (int k = 0; k < 8; k++) send(64'd10100, 2'd0, 48'h777 + 48'(k), acc_ts);
    chk("midrun_fifo_count", 64'(fifo_count), 64'd8);
    reset = 1'b1;
    @(posedge clk);
    @(posedge clk); #1;
    chk_all_zero("midrun_reset");
    chk("midrun_ts", timestamp, 64'd0);
    reset = 1'b0;
    wait_ts(64'd10150);
    chk("midrun_fifo_empty", 64'(fifo_count), 64'd0);
    chk("midrun_freq_untouched", 64'(freq), 64'd0);

    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
